instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch stage. Owns the PC, issues word fetches to instruction memory and
//  presents instruction_word + PC to the downstream control decoder (CONTROL_R) via a
//  valid/ready handshake. Honours redirects from branch/jump resolution. One outstanding
//  memory request at a time; a 1-entry skid register absorbs decoder back-pressure.
// PARAMETERS
//  XLEN      32            datapath / PC width
//  RESET_PC  32'h0000_0000 PC loaded on reset
//  NOP_INSN  32'h0000_0013 reset/flush value of instruction_word (addi x0,x0,0)
// PORTS
//  clk             in   1     rising-edge clock
//  rst             in   1     asynchronous, active-high reset
//  imem_req        out  1     fetch request valid
//  imem_addr       out  XLEN  fetch byte address, word aligned ([1:0]=0)
//  imem_gnt        in   1     request accepted this cycle (imem_req && imem_gnt)
//  imem_rvalid     in   1     read data valid (>=1 cycle after grant)
//  imem_rdata      in   32    fetched instruction
//  instruction_word out 32    instruction to decoder
//  inst_pc         out  XLEN  PC of instruction_word
//  inst_valid      out  1     instruction_word/inst_pc valid
//  inst_ready      in   1     decoder accepts (transfer = inst_valid && inst_ready)
//  redirect_valid  in   1     flush and restart fetch at redirect_pc
//  redirect_pc     in   XLEN  new PC; bits [1:0] ignored (forced 0)
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=S_IDLE, imem_req=0, imem_addr=RESET_PC, inst_valid=0,
//   instruction_word=NOP_INSN, inst_pc=0, skid empty. All regs async-cleared.
//  FSM: S_IDLE -> S_REQ unconditionally on first clock after reset release.
//   S_REQ : imem_req=1, imem_addr=pc. On gnt: req_pc<=pc, pc<=pc+4 (mod 2^XLEN, FFFF_FFFC->0),
//           go S_WAIT. No gnt: stay, imem_addr held stable.
//   S_WAIT: imem_req=0. On rvalid: if output free (!inst_valid || inst_ready) load
//           instruction_word<=rdata, inst_pc<=req_pc, inst_valid<=1, go S_REQ; else load
//           skid (data+pc), go S_HOLD.
//   S_HOLD: imem_req=0. On inst_ready: skid -> output regs, skid cleared, go S_REQ.
//   S_DRAIN: imem_req=0. Next rvalid discarded, go S_REQ. Entered only via redirect.
//  Output not loaded by skid/rvalid: inst_valid cleared on transfer, regs hold value.
//  Outputs held stable while inst_valid && !inst_ready.
//  Redirect (highest priority, any state): pc<=redirect_pc&~3, inst_valid<=0,
//   instruction_word<=NOP_INSN, skid cleared. Next state: S_DRAIN if a request is
//   outstanding (S_WAIT without rvalid this cycle, or S_REQ with gnt this cycle);
//   otherwise S_REQ. rvalid coincident with redirect in S_WAIT is dropped.
//  Latency: grant at edge N, rvalid in cycle N+1 -> inst_valid high after edge N+1.
//   Throughput with zero-wait memory and ready decoder: 1 instruction / 2 cycles.
//  Unsolicited rvalid (S_IDLE/S_REQ/S_HOLD) ignored. Reset mid-transaction: all state
//   cleared; a later rvalid for the lost request is ignored (FSM not in S_WAIT/S_DRAIN).
// STRUCTURE
//  fetch_defs.vh: FSM state localparam encodings (3-bit), NOP_INSN, RISC-V opcode
//   constants shared with CONTROL_R (OP_R=7'b0110011, OP_LOAD, OP_STORE, OP_LUI).
//  Sub-module fetch_skid_buf: 1-entry {pc,insn} register, load/unload/flush, full flag.
//  Top: PC register + adder, FSM, output register mux.
// TESTING
//  1 Reset, gnt=1, rvalid 1 cycle after gnt, rdata=32'h004A_82B3, ready=1 -> first
//    imem_addr=0, inst_valid with inst_pc=0, instruction_word=004A82B3; next imem_addr=4.
//  2 inst_ready=0 for 6 cycles -> one insn in output, second in skid, imem_req stays 0;
//    ready=1 -> PCs 0,4 delivered in order, no loss or duplication, then fetch at 8.
//  3 redirect_pc=32'h0000_0103 while S_WAIT -> stale rvalid dropped, next imem_addr=
//    32'h0000_0100, inst_valid=0 until new response.
//  4 pc=32'hFFFF_FFFC granted -> next imem_addr=32'h0000_0000.
//  5 rst pulsed high mid-S_WAIT, late rvalid arrives -> ignored; fetch restarts at RESET_PC,
//    instruction_word=NOP_INSN until first valid response.
//  6 imem_gnt withheld 3 cycles -> imem_req and imem_addr stable until grant.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_pkg
// Purpose  : Shared definitions for the instruction fetch stage: FSM state
//            encoding, reset/flush instruction value and the RISC-V opcode
//            constants also consumed by the downstream control decoder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_unit_pkg;

    // addi x0,x0,0 : presented on the decoder interface after reset or flush
    localparam logic [31:0] c_nop_insn = 32'h0000_0013;

    // Major opcodes shared with the control decoder
    localparam logic [6:0] c_op_r     = 7'b0110011;
    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;
    localparam logic [6:0] c_op_lui   = 7'b0110111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } fetch_state_e;

    function automatic logic [6:0] insn_opcode(input logic [31:0] insn);
        return insn[6:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_skid.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_skid
// Purpose  : One-entry {pc, insn} holding register that absorbs a fetched
//            instruction while the decoder output register is still occupied.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            i_load          - capture i_pc/i_insn, entry becomes full
//            i_unload        - entry consumed, becomes empty
//            i_flush         - discard entry (wins over load/unload)
//            i_pc, i_insn    - incoming entry
//            o_pc, o_insn    - stored entry
//            o_full          - entry holds valid data
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit_skid #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_unload,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_insn,
    output logic [XLEN-1:0] o_pc,
    output logic [31:0]     o_insn,
    output logic            o_full
);
    import instr_fetch_unit_pkg::*;

    logic            full_q, full_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     insn_q, insn_d;

    always_comb begin
        full_d = full_q;
        pc_d   = pc_q;
        insn_d = insn_q;
        if (i_flush) begin
            full_d = 1'b0;
        end else if (i_load) begin
            full_d = 1'b1;
            pc_d   = i_pc;
            insn_d = i_insn;
        end else if (i_unload) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            pc_q   <= '0;
            insn_q <= c_nop_insn;
        end else begin
            full_q <= full_d;
            pc_q   <= pc_d;
            insn_q <= insn_d;
        end
    end

    assign o_full = full_q;
    assign o_pc   = pc_q;
    assign o_insn = insn_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Instruction fetch stage. Owns the PC, issues one word fetch at a
//            time to instruction memory and hands {instruction_word, inst_pc}
//            to the control decoder over a valid/ready handshake. A one-entry
//            skid register absorbs decoder back-pressure; redirects flush the
//            pipe and restart fetch at the new PC.
// Ports    : clk, rst                  - clock, asynchronous active-high reset
//            imem_req/imem_addr        - fetch request and word-aligned address
//            imem_gnt                  - request accepted this cycle
//            imem_rvalid/imem_rdata    - fetch response
//            instruction_word/inst_pc  - instruction and its PC to decoder
//            inst_valid/inst_ready     - decoder handshake
//            redirect_valid/_pc        - flush and restart at redirect_pc
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_INSN = c_nop_insn
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instruction_word,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [31:0]     insn_q, insn_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            valid_q, valid_d;

    logic            w_xfer;
    logic            w_out_free;
    logic            w_outstanding;
    logic            w_skid_load;
    logic            w_skid_unload;
    logic            w_skid_flush;
    logic [XLEN-1:0] w_skid_pc;
    logic [31:0]     w_skid_insn;
    logic            w_skid_full;

    instr_fetch_unit_skid #(
        .XLEN (XLEN)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_flush  (w_skid_flush),
        .i_pc     (req_pc_q),
        .i_insn   (imem_rdata),
        .o_pc     (w_skid_pc),
        .o_insn   (w_skid_insn),
        .o_full   (w_skid_full)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        insn_d        = insn_q;
        inst_pc_d     = inst_pc_q;
        valid_d       = valid_q;
        w_skid_load   = 1'b0;
        w_skid_unload = 1'b0;
        w_skid_flush  = 1'b0;
        w_outstanding = 1'b0;

        w_xfer     = valid_q && inst_ready;
        w_out_free = !valid_q || inst_ready;

        // A completed transfer empties the output unless something below refills it
        if (w_xfer) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (w_out_free) begin
                        insn_d    = imem_rdata;
                        inst_pc_d = req_pc_q;
                        valid_d   = 1'b1;
                        state_d   = S_REQ;
                    end else begin
                        w_skid_load = 1'b1;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // Output is necessarily occupied here; ready means it drains this edge
                if (inst_ready && w_skid_full) begin
                    insn_d        = w_skid_insn;
                    inst_pc_d     = w_skid_pc;
                    valid_d       = 1'b1;
                    w_skid_unload = 1'b1;
                    state_d       = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Redirect overrides everything. If memory still owes a response
        // (including one granted this very cycle) it must be swallowed in
        // S_DRAIN so it cannot be mistaken for the redirected fetch.
        if (redirect_valid) begin
            pc_d          = redirect_pc & ~(XLEN'(3));
            valid_d       = 1'b0;
            insn_d        = NOP_INSN;
            w_skid_load   = 1'b0;
            w_skid_unload = 1'b0;
            w_skid_flush  = 1'b1;
            w_outstanding = ((state_q == S_WAIT)  && !imem_rvalid) ||
                            ((state_q == S_DRAIN) && !imem_rvalid) ||
                            ((state_q == S_REQ)   && imem_gnt);
            state_d       = w_outstanding ? S_DRAIN : S_REQ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            insn_q    <= NOP_INSN;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            insn_q    <= insn_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
        end
    end

    assign imem_req         = (state_q == S_REQ);
    assign imem_addr        = pc_q;
    assign instruction_word = insn_q;
    assign inst_pc          = inst_pc_q;
    assign inst_valid       = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit. A transaction-level
//            model (queue of instructions owed to the decoder, expected next
//            fetch address, in-flight memory response) is compared with the
//            DUT every cycle; directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC0 = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instruction_word;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    instr_fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .instruction_word (instruction_word),
        .inst_pc          (inst_pc),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } item_t;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model state ----------------
    item_t       dq[$];          // instructions owed to the decoder, oldest first
    logic [31:0] exp_fetch;      // address the next request must carry
    logic [31:0] idle_word;      // instruction_word expected while nothing is valid
    bit          outstanding;    // DUT is owed a response
    bit          mem_pending;    // memory has a response scheduled
    bit          mem_dead;       // that response must not reach the decoder
    bit          mem_fire;
    int          mem_wait;
    logic [31:0] mem_addr;
    int          xfer_count = 0;

    // ---------------- stimulus knobs ----------------
    int          p_gnt = 100, p_ready = 100, p_redir = 0, p_unsol = 0;
    int          dly_min = 0, dly_max = 0;
    bit          force_redir = 0;
    logic [31:0] force_rpc = '0;
    bit          use_fixed = 0;
    logic [31:0] fixed_word = '0;

    bit          ev_gnt, ev_xfer, ev_redir;
    logic [31:0] ev_rpc;

    // Memory content: a bijection of the address so every word is distinct
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (use_fixed) return fixed_word;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("inst_valid", 32'(inst_valid), 32'(dq.size() != 0));
        if (dq.size() != 0) begin
            chk("inst_pc", inst_pc, dq[0].pc);
            chk("instruction_word", instruction_word, dq[0].insn);
        end else begin
            chk("idle_word", instruction_word, idle_word);
        end
        if (imem_req) begin
            chk("imem_addr", imem_addr, exp_fetch);
            chk("req_while_outstanding", 32'(outstanding), 32'd0);
            chk("req_while_two_buffered", 32'(dq.size() >= 2), 32'd0);
        end
    endtask

    function automatic logic [31:0] pick_rpc();
        case ($urandom_range(3))
            0:       return 32'hFFFF_FFF0 + 32'($urandom_range(15));
            1:       return 32'($urandom_range(63));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_inputs();
        imem_gnt   = (int'($urandom_range(99)) < p_gnt) && !mem_pending;
        inst_ready = int'($urandom_range(99)) < p_ready;
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_rpc;
        end else if (int'($urandom_range(99)) < p_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = pick_rpc();
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
        end
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        mem_fire    = 1'b0;
        if (mem_pending) begin
            if (mem_wait == 0) begin
                imem_rvalid = 1'b1;
                mem_fire    = 1'b1;
                imem_rdata  = mem_dead ? $urandom : mem_word(mem_addr);
            end else begin
                mem_wait--;
            end
        end else if (int'($urandom_range(99)) < p_unsol) begin
            imem_rvalid = 1'b1;   // unsolicited, must be ignored
        end
        ev_gnt   = imem_req && imem_gnt;
        ev_xfer  = inst_valid && inst_ready;
        ev_redir = redirect_valid;
        ev_rpc   = redirect_pc;
    endtask

    task automatic update_model();
        if (ev_xfer && dq.size() != 0) begin
            idle_word = dq[0].insn;
            void'(dq.pop_front());
            xfer_count++;
        end
        if (mem_fire) begin
            if (!mem_dead) dq.push_back('{pc: mem_addr, insn: mem_word(mem_addr)});
            mem_pending = 0;
            outstanding = 0;
        end
        if (ev_gnt) begin
            mem_pending = 1;
            mem_dead    = 0;
            mem_addr    = exp_fetch;
            mem_wait    = $urandom_range(dly_max, dly_min);
            outstanding = 1;
            exp_fetch   = exp_fetch + 32'd4;
        end
        if (ev_redir) begin
            dq.delete();
            idle_word = NOP;
            if (mem_pending) mem_dead = 1;
            exp_fetch = ev_rpc & ~32'd3;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        drive_inputs();
        @(posedge clk);
        update_model();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        imem_gnt = 0; imem_rvalid = 0; inst_ready = 0; redirect_valid = 0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        dq.delete();
        outstanding = 0;
        if (mem_pending) mem_dead = 1;
        exp_fetch = RPC0;
        idle_word = NOP;
        #1;
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_instruction_word", instruction_word, NOP);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, RPC0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic set_knobs(input int g, input int r, input int rd, input int un,
                             input int dmin, input int dmax);
        p_gnt = g; p_ready = r; p_redir = rd; p_unsol = un; dly_min = dmin; dly_max = dmax;
    endtask

    int x0;

    initial begin
        mem_pending = 0; mem_dead = 0; outstanding = 0; mem_wait = 0; mem_addr = '0;
        exp_fetch = RPC0; idle_word = NOP;

        // ---- 1: basic fetch, latency and throughput ----
        use_fixed = 1; fixed_word = 32'h004A_82B3;
        set_knobs(100, 100, 0, 0, 0, 0);
        do_reset();
        step(); #2;
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_addr0", imem_addr, 32'h0);
        step(); step(); #2;
        chk("t1_valid", 32'(inst_valid), 32'd1);
        chk("t1_pc", inst_pc, 32'h0);
        chk("t1_word", instruction_word, 32'h004A_82B3);
        chk("t1_addr4", imem_addr, 32'h4);
        x0 = xfer_count;
        steps(20);
        chk("t1_throughput", 32'(xfer_count - x0), 32'd10);
        use_fixed = 0;

        // ---- 2: back-pressure fills output and skid ----
        set_knobs(100, 0, 0, 0, 0, 0);
        do_reset();
        steps(8); #2;
        chk("t2_req_blocked", 32'(imem_req), 32'd0);
        chk("t2_valid", 32'(inst_valid), 32'd1);
        chk("t2_pc_held", inst_pc, 32'h0);
        p_ready = 100;
        step(); #2;
        chk("t2_pc_next", inst_pc, 32'h4);
        chk("t2_word_next", instruction_word, mem_word(32'h4));
        chk("t2_req_resume", 32'(imem_req), 32'd1);
        chk("t2_addr8", imem_addr, 32'h8);
        steps(6);

        // ---- 3: redirect while a fetch is outstanding ----
        set_knobs(100, 100, 0, 0, 2, 2);
        do_reset();
        step(); step();
        force_redir = 1; force_rpc = 32'h0000_0103;
        step(); #2;
        force_redir = 0;
        chk("t3_req_drain", 32'(imem_req), 32'd0);
        chk("t3_valid_flush", 32'(inst_valid), 32'd0);
        step(); step(); #2;
        chk("t3_addr_redir", imem_addr, 32'h0000_0100);
        chk("t3_req_redir", 32'(imem_req), 32'd1);
        chk("t3_no_stale", 32'(inst_valid), 32'd0);
        steps(4); #2;
        chk("t3_new_valid", 32'(inst_valid), 32'd1);
        chk("t3_new_pc", inst_pc, 32'h0000_0100);

        // ---- 4: PC wrap at the top of the address space ----
        set_knobs(100, 100, 0, 0, 0, 0);
        do_reset();
        force_redir = 1; force_rpc = 32'hFFFF_FFFF;
        step(); #2;
        force_redir = 0;
        chk("t4_addr_top", imem_addr, 32'hFFFF_FFFC);
        step(); step(); #2;
        chk("t4_addr_wrap", imem_addr, 32'h0);
        chk("t4_pc_top", inst_pc, 32'hFFFF_FFFC);

        // ---- 5: reset mid-transaction, late response ignored ----
        set_knobs(100, 100, 0, 0, 4, 4);
        do_reset();
        step(); step(); step();
        do_reset();
        for (int i = 0; i < 20 && mem_pending; i++) begin
            step(); #2;
            chk("t5_valid_low", 32'(inst_valid), 32'd0);
            chk("t5_word_nop", instruction_word, NOP);
        end
        chk("t5_late_rsp_seen", 32'(mem_pending), 32'd0);
        dly_min = 0; dly_max = 0;
        step(); step(); #2;
        chk("t5_restart_valid", 32'(inst_valid), 32'd1);
        chk("t5_restart_pc", inst_pc, 32'h0);

        // ---- 6: grant withheld ----
        set_knobs(0, 100, 0, 0, 0, 0);
        do_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            step(); #2;
            chk("t6_req_held", 32'(imem_req), 32'd1);
            chk("t6_addr_held", imem_addr, 32'h0);
        end
        p_gnt = 100;
        step(); #2;
        chk("t6_req_after_gnt", 32'(imem_req), 32'd0);

        // ---- randomized traffic ----
        for (int blk = 0; blk < 20; blk++) begin
            set_knobs($urandom_range(100, 20), $urandom_range(100, 10), $urandom_range(8),
                      $urandom_range(15), 0, $urandom_range(4));
            if ($urandom_range(3) == 0) do_reset();
            steps(200);
        end

        // ---- cooperative tail: the pipe must keep flowing ----
        set_knobs(100, 100, 0, 0, 0, 0);
        steps(10);
        x0 = xfer_count;
        steps(200);
        chk("tail_throughput", 32'(xfer_count - x0 >= 90), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
